// File: rtl/hall_call_panel.sv
// rtl/hall_call_panel.sv - hall-button call latch with round-robin request issue and periodic retry
module hall_call_panel #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 3,
  parameter int HOLD_CYCLES  = 2,
  parameter int RETRY_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] up_btn,
  input  logic [NUM_FLOORS-1:0] down_btn,
  input  logic                  serviced_valid,
  input  logic [FLOOR_W-1:0]    serviced_floor,
  input  logic                  serviced_dir,
  output logic                  request,
  output logic [FLOOR_W-1:0]    request_floor,
  output logic                  request_dir,
  output logic [NUM_FLOORS-1:0] up_lamp,
  output logic [NUM_FLOORS-1:0] down_lamp
);

  localparam int SLOTS   = 2 * NUM_FLOORS;
  localparam int SLOT_W  = $clog2(SLOTS);
  localparam int TIMER_W = $clog2(RETRY_CYCLES);
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(RETRY_CYCLES - 1);
  // No up call from the top floor, no down call from the ground floor.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t              state;
  logic [SLOTS-1:0]    pending;
  logic [SLOTS-1:0]    dispatched;
  logic [SLOTS-1:0]    set_vec;
  logic [SLOTS-1:0]    svc_vec;
  logic [SLOTS-1:0]    eligible;
  logic [SLOTS-1:0]    disp_next;
  logic [SLOT_W-1:0]   ptr;
  logic [SLOT_W-1:0]   grant_slot;
  logic [SLOT_W-1:0]   cand;
  logic [SLOT_W-1:0]   svc_idx;
  logic                grant_valid;
  logic                wrap;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [TIMER_W-1:0]  timer;

  assign set_vec   = {down_btn & DN_MASK, up_btn & UP_MASK};
  assign wrap      = (timer == TIMER_LAST);
  assign eligible  = pending & ~dispatched & ~svc_vec;
  assign up_lamp   = pending[NUM_FLOORS-1:0];
  assign down_lamp = pending[SLOTS-1:NUM_FLOORS];

  always_comb begin
    svc_vec = '0;
    svc_idx = serviced_dir ? SLOT_W'(serviced_floor) : SLOT_W'(int'(serviced_floor) + NUM_FLOORS);
    if (serviced_valid && (int'(serviced_floor) < NUM_FLOORS))
      svc_vec[svc_idx] = 1'b1;
  end

  // First eligible slot at or after ptr, wrapping upward.
  always_comb begin
    grant_valid = 1'b0;
    grant_slot  = '0;
    cand        = '0;
    for (int i = 0; i < SLOTS; i++) begin
      cand = SLOT_W'((int'(ptr) + i) % SLOTS);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_slot  = cand;
      end
    end
  end

  // A grant on the wrap edge keeps its dispatched bit.
  always_comb begin
    disp_next = wrap ? '0 : dispatched;
    disp_next = disp_next & ~svc_vec;
    if (state == IDLE && grant_valid)
      disp_next[grant_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= '0;
      dispatched    <= '0;
      ptr           <= '0;
      hold_cnt      <= '0;
      timer         <= '0;
      request       <= 1'b0;
      request_floor <= '0;
      request_dir   <= 1'b0;
    end else begin
      pending    <= (pending | set_vec) & ~svc_vec;
      dispatched <= disp_next;
      timer      <= wrap ? '0 : timer + 1'b1;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            request       <= 1'b1;
            request_floor <= FLOOR_W'(int'(grant_slot) % NUM_FLOORS);
            request_dir   <= (int'(grant_slot) < NUM_FLOORS);
            ptr           <= SLOT_W'((int'(grant_slot) + 1) % SLOTS);
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          request  <= 1'b0;
          hold_cnt <= '0;
          state    <= (HOLD_CYCLES == 0) ? IDLE : HOLD;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST)
            state <= IDLE;
          else
            hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hall_call_panel.sv
// tb/tb_hall_call_panel.sv - directed and randomized checks of hall_call_panel against a slot-level model
module tb_hall_call_panel;

  localparam int NF = 8;
  localparam int FW = 3;
  localparam int HC = 2;
  localparam int RC = 16;
  localparam int NS = 2 * NF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] up_btn = '0;
  logic [NF-1:0] down_btn = '0;
  logic          serviced_valid = 1'b0;
  logic [FW-1:0] serviced_floor = '0;
  logic          serviced_dir = 1'b0;
  logic          request;
  logic [FW-1:0] request_floor;
  logic          request_dir;
  logic [NF-1:0] up_lamp;
  logic [NF-1:0] down_lamp;

  hall_call_panel #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .HOLD_CYCLES(HC), .RETRY_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .up_btn(up_btn), .down_btn(down_btn),
    .serviced_valid(serviced_valid), .serviced_floor(serviced_floor), .serviced_dir(serviced_dir),
    .request(request), .request_floor(request_floor), .request_dir(request_dir),
    .up_lamp(up_lamp), .down_lamp(down_lamp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Model: call flags per slot, edge count since reset, earliest edge allowed to grant.
  bit m_pend[NS];
  bit m_disp[NS];
  int m_ptr = 0;
  int m_k = 0;
  int m_next_ok = 0;
  bit m_req = 1'b0;
  int m_floor = 0;
  bit m_dir = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NF-1:0] m_lamps(input bit up);
    logic [NF-1:0] v;
    for (int f = 0; f < NF; f++) v[f] = up ? m_pend[f] : m_pend[f+NF];
    return v;
  endfunction

  task automatic model_step();
    int s;
    int g;
    int c;
    bit grant;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin m_pend[i] = 1'b0; m_disp[i] = 1'b0; end
      m_req = 1'b0; m_floor = 0; m_dir = 1'b0; m_ptr = 0; m_k = 0; m_next_ok = 0;
      return;
    end
    s = serviced_valid ? (serviced_dir ? int'(serviced_floor) : int'(serviced_floor) + NF) : -1;
    grant = 1'b0;
    g = 0;
    if (m_k >= m_next_ok) begin
      for (int i = 0; i < NS; i++) begin
        c = (m_ptr + i) % NS;
        if (!grant && m_pend[c] && !m_disp[c] && c != s) begin grant = 1'b1; g = c; end
      end
    end
    for (int f = 0; f < NF; f++) begin
      if (up_btn[f] && f != NF-1) m_pend[f] = 1'b1;
      if (down_btn[f] && f != 0) m_pend[f+NF] = 1'b1;
    end
    if (m_k % RC == RC-1)
      for (int i = 0; i < NS; i++) m_disp[i] = 1'b0;
    if (s >= 0) begin m_pend[s] = 1'b0; m_disp[s] = 1'b0; end
    m_req = grant;
    if (grant) begin
      m_disp[g] = 1'b1;
      m_ptr = (g + 1) % NS;
      m_floor = g % NF;
      m_dir = (g < NF);
      m_next_ok = m_k + HC + 2;
    end
    m_k++;
  endtask

  // One clock: model advances at the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("m_request", request, m_req);
    check("m_up_lamp", up_lamp, m_lamps(1'b1));
    check("m_down_lamp", down_lamp, m_lamps(1'b0));
    if (m_req) begin
      check("m_floor", request_floor, m_floor);
      check("m_dir", request_dir, m_dir);
    end
    if (request === 1'b1) pulses++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic service(input int floor, input bit dir);
    serviced_valid = 1'b1;
    serviced_floor = FW'(floor);
    serviced_dir = dir;
    tick();
    serviced_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int st;
    int pick;
    int exp_f[3];
    bit exp_d[3];

    // Reset state
    do_reset();
    check("rst_request", request, 0);
    check("rst_floor", request_floor, 0);
    check("rst_dir", request_dir, 0);
    check("rst_up_lamp", up_lamp, 0);
    check("rst_down_lamp", down_lamp, 0);

    // Single up call at floor 3
    tick();
    up_btn = 8'h08;
    tick();
    up_btn = '0;
    check("t1_lamp", up_lamp, 8'h08);
    check("t1_no_req_yet", request, 0);
    tick();
    check("t1_req", request, 1);
    check("t1_floor", request_floor, 3);
    check("t1_dir", request_dir, 1);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("t1_single_pulse", request, 0);
    end
    service(3, 1'b1);
    check("t1_serviced_lamp", up_lamp, 0);

    // Three simultaneous calls, round-robin from slot 0
    do_reset();
    tick();
    up_btn = 8'b0000_0101;
    down_btn = 8'b0010_0000;
    tick();
    up_btn = '0;
    down_btn = '0;
    exp_f[0] = 0; exp_d[0] = 1'b1;
    exp_f[1] = 2; exp_d[1] = 1'b1;
    exp_f[2] = 5; exp_d[2] = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      tick();
      if (j % 4 == 1) begin
        check("t2_req", request, 1);
        check("t2_floor", request_floor, exp_f[j/4]);
        check("t2_dir", request_dir, exp_d[j/4]);
      end else begin
        check("t2_gap", request, 0);
      end
    end
    service(0, 1'b1);
    service(2, 1'b1);
    service(5, 1'b0);
    check("t2_up_clear", up_lamp, 0);
    check("t2_down_clear", down_lamp, 0);

    // Serviced call is not re-issued across retry wraps
    do_reset();
    tick();
    down_btn = 8'h10;
    tick();
    down_btn = '0;
    tick();
    check("t3_req", request, 1);
    check("t3_floor", request_floor, 4);
    check("t3_dir", request_dir, 0);
    service(4, 1'b0);
    check("t3_lamp_off", down_lamp, 0);
    c0 = pulses;
    repeat (40) tick();
    check("t3_no_reissue", pulses - c0, 0);

    // Unserviced call is re-issued after the retry wrap
    do_reset();
    tick();
    up_btn = 8'h40;
    tick();
    up_btn = '0;
    tick();
    check("t4_req", request, 1);
    check("t4_floor", request_floor, 6);
    c0 = pulses;
    repeat (20) tick();
    check("t4_reissue_count", pulses - c0, 1);
    check("t4_lamp_on", up_lamp, 8'h40);
    service(6, 1'b1);

    // Press and service on the same edge; ignored buttons
    do_reset();
    tick();
    up_btn = 8'h02;
    serviced_valid = 1'b1;
    serviced_floor = 3'd1;
    serviced_dir = 1'b1;
    tick();
    up_btn = '0;
    serviced_valid = 1'b0;
    check("t5_clear_wins", up_lamp, 0);
    c0 = pulses;
    repeat (6) tick();
    check("t5_no_pulse", pulses - c0, 0);
    up_btn = 8'h80;
    down_btn = 8'h01;
    tick();
    up_btn = '0;
    down_btn = '0;
    check("t5_ign_up", up_lamp, 0);
    check("t5_ign_down", down_lamp, 0);
    c0 = pulses;
    repeat (6) tick();
    check("t5_ign_no_pulse", pulses - c0, 0);

    // Reset during the ISSUE cycle
    do_reset();
    tick();
    up_btn = 8'h04;
    tick();
    up_btn = '0;
    tick();
    check("t6_in_issue", request, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_req_drop", request, 0);
    check("t6_lamps", {up_lamp, down_lamp}, 0);
    tick();
    up_btn = 8'h20;
    tick();
    up_btn = '0;
    tick();
    check("t6_new_req", request, 1);
    check("t6_new_floor", request_floor, 5);
    check("t6_new_dir", request_dir, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      up_btn = ($urandom_range(0, 3) == 0) ? NF'($urandom & $urandom) : '0;
      down_btn = ($urandom_range(0, 3) == 0) ? NF'($urandom & $urandom) : '0;
      serviced_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        st = $urandom_range(0, NS-1);
        pick = st;
        if ($urandom_range(0, 3) != 0)
          for (int i = NS-1; i >= 0; i--)
            if (m_pend[(st + i) % NS]) pick = (st + i) % NS;
        serviced_valid = 1'b1;
        serviced_floor = FW'(pick % NF);
        serviced_dir = (pick < NF);
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    up_btn = '0;
    down_btn = '0;
    serviced_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hall_call_panel.md
# hall_call_panel

Hall-side initiator for the building dispatcher's hall-request interface. It latches up/down hall-button presses per floor and drives the lamps. Each outstanding call is issued to the dispatcher as a one-cycle `request` pulse carrying `request_floor`/`request_dir`, using round-robin arbitration. A call is cleared when an elevator reports servicing that floor and direction. Calls still unserviced when a periodic retry timer expires are re-issued.

## Interface
- `NUM_FLOORS`, 8: floors served; call slots = 2*NUM_FLOORS.
- `FLOOR_W`, 3: floor index width; matches `request_floor`.
- `HOLD_CYCLES`, 2: idle cycles after each `request` pulse before the next arbitration.
- `RETRY_CYCLES`, 1024: retry timer period; ≥2.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `up_btn` input NUM_FLOORS: level, bit f = up call at floor f; bit NUM_FLOORS-1 ignored.
- `down_btn` input NUM_FLOORS: level, bit f = down call at floor f; bit 0 ignored.
- `serviced_valid` input 1: an elevator is servicing (`serviced_floor`, `serviced_dir`) this cycle.
- `serviced_floor` input FLOOR_W: floor being serviced.
- `serviced_dir` input 1: 1 = up, 0 = down.
- `request` output 1: one-cycle hall-request strobe to the dispatcher.
- `request_floor` output FLOOR_W: floor of issued call; valid only while `request`=1.
- `request_dir` output 1: direction of issued call, 1 = up, 0 = down; valid only while `request`=1.
- `up_lamp` output NUM_FLOORS: pending up calls.
- `down_lamp` output NUM_FLOORS: pending down calls.

## Operation
- Slot s: s<NUM_FLOORS → up call at floor s; otherwise → down call at floor s-NUM_FLOORS.
- Each slot has `pending` and `dispatched` flags. `up_lamp`/`down_lamp` equal the pending flags.
- Set: a button bit high at an edge sets `pending` for its slot. Ignored bits never set.
- Clear: `serviced_valid` at an edge clears both `pending` and `dispatched` of the matching slot.
  - Clear beats a same-edge set.
  - A service report for a slot that is not pending has no effect.
- Eligible mask = pending & ~dispatched & ~(same-cycle service match).
- Round-robin arbitration:
  - Pointer `ptr` (0..2*NUM_FLOORS-1) marks the highest-priority slot.
  - The search starts at `ptr` and wraps upward.
  - After a grant of slot g, `ptr` = (g+1) mod 2*NUM_FLOORS.
- FSM:
  - IDLE: if any slot is eligible, grant the winner. At the same edge, load the `request` outputs, set the winner's `dispatched`, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `request`=1 for exactly this cycle. At the next edge, go to HOLD with the hold counter=0.
  - HOLD: count to HOLD_CYCLES-1, then go to IDLE. If HOLD_CYCLES=0, ISSUE goes straight to IDLE.
- Retry timer:
  - Free-running, 0..RETRY_CYCLES-1.
  - On wrap, all `dispatched` flags clear; `pending` flags are untouched.
  - If a grant lands on the same edge as the wrap, the granted slot's `dispatched` set wins.
- A service clear arriving while in ISSUE/HOLD does not cancel the pulse already on the outputs.
- Reset:
  - All flags 0, `ptr`=0, FSM=IDLE, hold counter and retry timer 0.
  - Outputs: `request`=0, `request_floor`=0, `request_dir`=0, lamps all 0.
  - Reset mid-pulse drops `request` at the next edge; that call is lost and must be pressed again.

## Timing
- Button sampled at edge E0 → lamp high after E0.
- If the FSM was in IDLE at E0 and the slot wins, `request` is high in the cycle after E1, i.e. 2-edge latency.
- `request` is exactly 1 cycle wide. Outputs are registered; there are no combinational input→output paths.
- Minimum spacing between pulse rising edges = HOLD_CYCLES + 2 cycles (4 at the default).
- Service at edge E → lamp low after E.
- Re-issue of an unserviced call happens no later than RETRY_CYCLES + 2*NUM_FLOORS*(HOLD_CYCLES+2) cycles after its previous issue.

## Test plan
- Reset, then press `up_btn[3]` for 1 cycle → `up_lamp[3]`=1 next cycle; `request`=1 for 1 cycle with floor=3, dir=1, 2 edges after the press; no second pulse.
- Press `up_btn[2]`, `down_btn[5]`, `up_btn[0]` in the same cycle with `ptr`=0 → pulses in order (0,up), (2,up), (5,down) (slot 13), spaced 4 cycles apart.
- Pending (4,down) issued, then `serviced_valid` with floor=4, dir=0 → `down_lamp[4]`=0 next cycle; no re-issue after the retry wrap.
- Pending (6,up) never serviced, RETRY_CYCLES=16 → second pulse for (6,up) after the timer wraps; lamp stays on.
- Press `up_btn[1]` and service (1,up) on the same edge → lamp stays 0 and no pulse. Press `up_btn[7]`/`down_btn[0]` → ignored, no lamp, no pulse.
- Assert `reset` during the ISSUE cycle → `request`=0, lamps 0, FSM in IDLE next cycle; a new press afterwards issues normally.
